// File: rtl/weight_update_d_pkg.sv
// Shared Q-format defaults and the saturation classifier used by the weight-update
// and dot-product datapaths.
package weight_update_d_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int QP_DEF    = 12;
  localparam int LEN_DEF   = 8;
  localparam int ONE       = 1 << QP_DEF;

  typedef enum logic [1:0] {
    SAT_PASS = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  // Decide whether a wide signed value fits a width-bit signed word or must clip.
  function automatic sat_e sat_classify(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return SAT_POS;
    if (v < lo) return SAT_NEG;
    return SAT_PASS;
  endfunction

endpackage

// File: rtl/sat_mac_lane.sv
// One weight lane: registered mu_err*x product, floor shift, saturating
// accumulate onto the lane's weight register.
module sat_mac_lane
  import weight_update_d_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int QP    = QP_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture,
  input  logic                    write,
  input  logic                    clear,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] mu_err,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] load_w,
  output logic signed [WIDTH-1:0] w
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = PW - QP + 1;

  logic signed [PW-1:0]    prod;
  logic signed [PW-QP-1:0] step;
  logic signed [SW-1:0]    sum;
  logic signed [63:0]      sum_wide;
  logic signed [WIDTH-1:0] w_next;
  sat_e                    sat_sel;

  // Dropping the low QP bits of a two's-complement value is a floor shift.
  assign step     = prod[PW-1:QP];
  assign sum      = {{(SW-WIDTH){w[WIDTH-1]}}, w} + {step[PW-QP-1], step};
  assign sum_wide = {{(64-SW){sum[SW-1]}}, sum};
  assign sat_sel  = sat_classify(sum_wide, WIDTH);

  always_comb begin
    w_next = sum[WIDTH-1:0];
    case (sat_sel)
      SAT_POS: w_next = {1'b0, {(WIDTH-1){1'b1}}};
      SAT_NEG: w_next = {1'b1, {(WIDTH-1){1'b0}}};
      default: w_next = sum[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod <= '0;
      w    <= '0;
    end else begin
      if (capture) prod <= mu_err * x;
      if (clear)      w <= '0;
      else if (load)  w <= load_w;
      else if (write) w <= w_next;
    end
  end

endmodule

// File: rtl/weight_update_d.sv
// LEN-tap weight register with a two-stage saturating LMS-style update:
// w[i] <= sat(w[i] + (mu_err*x[i]) >>> QP), one update per cycle.
module weight_update_d
  import weight_update_d_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int QP    = QP_DEF,
  parameter int LEN   = LEN_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   upd_valid,
  input  logic [WIDTH-1:0]       mu_err,
  input  logic [LEN*WIDTH-1:0]   x_packed,
  input  logic                   load_en,
  input  logic [LEN*WIDTH-1:0]   load_packed,
  input  logic                   clear,
  output logic [LEN*WIDTH-1:0]   w_packed,
  output logic                   w_valid,
  output logic                   busy
);

  // upd_valid is a single-cycle request with no ready: the block never stalls.
  // Every request not masked by clear/load_en in the same cycle yields exactly
  // one w_valid pulse two edges later, and clear/load_en discard a request
  // already sitting in stage 1.
  logic s1_v;
  logic capture;

  assign capture = upd_valid & ~clear & ~load_en;
  assign busy    = s1_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v    <= 1'b0;
      w_valid <= 1'b0;
    end else if (clear || load_en) begin
      s1_v    <= 1'b0;
      w_valid <= 1'b0;
    end else begin
      s1_v    <= upd_valid;
      w_valid <= s1_v;
    end
  end

  for (genvar i = 0; i < LEN; i++) begin : g_lane
    logic signed [WIDTH-1:0] w_lane;

    sat_mac_lane #(.WIDTH(WIDTH), .QP(QP)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .capture (capture),
      .write   (s1_v),
      .clear   (clear),
      .load    (load_en),
      .mu_err  (mu_err),
      .x       (x_packed[i*WIDTH +: WIDTH]),
      .load_w  (load_packed[i*WIDTH +: WIDTH]),
      .w       (w_lane)
    );

    assign w_packed[i*WIDTH +: WIDTH] = w_lane;
  end

endmodule

// File: tb/tb_weight_update_d.sv
// Bench for weight_update_d: directed scenarios plus a randomized run against a
// transaction-level model of the weight vector.
module tb_weight_update_d;
  import weight_update_d_pkg::*;

  localparam int WIDTH = 16;
  localparam int QP    = 12;
  localparam int LEN   = 8;
  localparam int VW    = LEN * WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          upd_valid;
  logic [WIDTH-1:0] mu_err;
  logic [VW-1:0] x_packed;
  logic          load_en;
  logic [VW-1:0] load_packed;
  logic          clear;
  logic [VW-1:0] w_packed;
  logic          w_valid;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VW-1:0] exp_q[$];
  int            mw[LEN];
  int            pend_x[LEN];
  int            pend_mu;
  bit            pend_v;

  weight_update_d #(.WIDTH(WIDTH), .QP(QP), .LEN(LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .upd_valid   (upd_valid),
    .mu_err      (mu_err),
    .x_packed    (x_packed),
    .load_en     (load_en),
    .load_packed (load_packed),
    .clear       (clear),
    .w_packed    (w_packed),
    .w_valid     (w_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] splat(input logic [WIDTH-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LEN; i++) r[i*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  function automatic int sx(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  // w + floor(mu*x / 2^QP), clamped to the signed 16-bit range.
  function automatic int lane_next(input int w, input int mu, input int x);
    longint p, fl, s;
    p  = longint'(mu) * longint'(x);
    fl = p / longint'(ONE);
    if ((p % longint'(ONE)) != 0 && p < 0) fl = fl - 1;
    s = longint'(w) + fl;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic logic [VW-1:0] pack_model();
    logic [VW-1:0] r;
    for (int i = 0; i < LEN; i++) r[i*WIDTH +: WIDTH] = WIDTH'(mw[i]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [VW-1:0] v);
    load_en = 1'b1;
    load_packed = v;
    tick();
    load_en = 1'b0;
    for (int i = 0; i < LEN; i++) mw[i] = sx(v[i*WIDTH +: WIDTH]);
    pend_v = 1'b0;
  endtask

  task automatic do_update(input logic [WIDTH-1:0] mu, input logic [VW-1:0] x);
    upd_valid = 1'b1;
    mu_err = mu;
    x_packed = x;
    tick();
    upd_valid = 1'b0;
    mu_err = $urandom_range(0, 65535);
    x_packed = {LEN{16'hDEAD}};
    tick();
  endtask

  task automatic test_reset();
    n_checks++; if (w_packed !== '0) begin n_fail++; $display("FAIL reset_w got=%h exp=0", w_packed); end
    n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wv got=%b exp=0", w_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
    do_load(splat(16'h1234));
    upd_valid = 1'b1; mu_err = 16'h0800; x_packed = splat(16'h1000);
    tick();
    upd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (w_packed !== '0) begin n_fail++; $display("FAIL reset_async_w got=%h exp=0", w_packed); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_async_busy got=%b exp=0", busy); end
    n_checks++; if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_async_wv got=%b exp=0", w_valid); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (w_packed !== '0 || w_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold w=%h wv=%b busy=%b exp=0/0/0", w_packed, w_valid, busy);
      end
    end
  endtask

  task automatic test_basic();
    do_load(splat(16'h1000));
    upd_valid = 1'b1; mu_err = 16'h0800; x_packed = splat(16'h1000);
    tick();
    upd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || w_valid !== 1'b0) begin n_fail++; $display("FAIL basic_s1 busy=%b wv=%b exp=1/0", busy, w_valid); end
    n_checks++; if (w_packed !== splat(16'h1000)) begin n_fail++; $display("FAIL basic_early_w got=%h exp=%h", w_packed, splat(16'h1000)); end
    tick();
    n_checks++; if (w_packed !== splat(16'h1800)) begin n_fail++; $display("FAIL basic_w got=%h exp=%h", w_packed, splat(16'h1800)); end
    n_checks++; if (w_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_wv wv=%b busy=%b exp=1/0", w_valid, busy); end
    tick();
    n_checks++; if (w_valid !== 1'b0 || w_packed !== splat(16'h1800)) begin n_fail++; $display("FAIL basic_after wv=%b w=%h", w_valid, w_packed); end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] ld, xv, ex;
    do_load(splat(16'h7000));
    do_update(16'h7FFF, splat(16'h7FFF));
    n_checks++; if (w_packed !== splat(16'h7FFF)) begin n_fail++; $display("FAIL sat_pos got=%h exp=%h", w_packed, splat(16'h7FFF)); end
    do_load(splat(16'h9000));
    do_update(16'h7FFF, splat(16'h8001));
    n_checks++; if (w_packed !== splat(16'h8000)) begin n_fail++; $display("FAIL sat_neg got=%h exp=%h", w_packed, splat(16'h8000)); end
    for (int i = 0; i < LEN; i++) begin
      ld[i*WIDTH +: WIDTH] = (i % 2 == 0) ? 16'h7000 : 16'h9000;
      xv[i*WIDTH +: WIDTH] = (i % 2 == 0) ? 16'h7FFF : 16'h8001;
      ex[i*WIDTH +: WIDTH] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
    end
    do_load(ld);
    do_update(16'h7FFF, xv);
    n_checks++; if (w_packed !== ex) begin n_fail++; $display("FAIL sat_mixed got=%h exp=%h", w_packed, ex); end
  endtask

  task automatic test_floor();
    do_load('0);
    do_update(16'h0001, splat(16'h0001));
    n_checks++; if (w_packed !== '0) begin n_fail++; $display("FAIL floor_pos got=%h exp=0", w_packed); end
    do_update(16'hFFFF, splat(16'h0001));
    n_checks++; if (w_packed !== splat(16'hFFFF)) begin n_fail++; $display("FAIL floor_neg got=%h exp=%h", w_packed, splat(16'hFFFF)); end
    do_update(16'hFFFF, splat(16'h1000));
    n_checks++; if (w_packed !== splat(16'hFFFE)) begin n_fail++; $display("FAIL floor_exact got=%h exp=%h", w_packed, splat(16'hFFFE)); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_w[5];
    logic             exp_v[5];
    exp_w = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0300};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_load('0);
    mu_err = 16'h0100; x_packed = splat(16'h1000);
    for (int c = 0; c < 5; c++) begin
      upd_valid = (c < 3);
      tick();
      n_checks++; if (w_packed !== splat(exp_w[c]) || w_valid !== exp_v[c]) begin
        n_fail++; $display("FAIL b2b_c%0d w=%h wv=%b exp=%h/%b", c, w_packed, w_valid, splat(exp_w[c]), exp_v[c]);
      end
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_precedence();
    do_load('0);
    upd_valid = 1'b1; mu_err = 16'h0100; x_packed = splat(16'h1000);
    tick();
    upd_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prec_busy got=%b exp=1", busy); end
    load_en = 1'b1; load_packed = splat(16'h0400);
    tick();
    load_en = 1'b0;
    n_checks++; if (w_packed !== splat(16'h0400) || w_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL prec_load w=%h wv=%b busy=%b exp=%h/0/0", w_packed, w_valid, busy, splat(16'h0400));
    end
    tick();
    n_checks++; if (w_packed !== splat(16'h0400) || w_valid !== 1'b0) begin n_fail++; $display("FAIL prec_load_hold w=%h wv=%b", w_packed, w_valid); end
    clear = 1'b1; upd_valid = 1'b1;
    tick();
    clear = 1'b0; upd_valid = 1'b0;
    n_checks++; if (w_packed !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL prec_clear w=%h busy=%b exp=0/0", w_packed, busy); end
    tick();
    n_checks++; if (w_packed !== '0 || w_valid !== 1'b0) begin n_fail++; $display("FAIL prec_clear_hold w=%h wv=%b exp=0/0", w_packed, w_valid); end
    load_en = 1'b1; load_packed = splat(16'h0200); upd_valid = 1'b1;
    tick();
    load_en = 1'b0; upd_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prec_load_drop busy=%b exp=0", busy); end
    tick();
    n_checks++; if (w_packed !== splat(16'h0200) || w_valid !== 1'b0) begin n_fail++; $display("FAIL prec_load_drop_w w=%h wv=%b", w_packed, w_valid); end
  endtask

  task automatic test_random();
    logic [VW-1:0] got_exp;
    int r;
    bit exp_wv;
    do_load('0);
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      clear = (r < 3);
      load_en = (r >= 3 && r < 8);
      upd_valid = ($urandom_range(0, 3) != 0);
      mu_err = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 65535)) : WIDTH'($urandom_range(0, 511) - 256);
      for (int i = 0; i < LEN; i++) begin
        x_packed[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
        load_packed[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
      end
      exp_wv = 1'b0;
      if (clear) begin
        for (int i = 0; i < LEN; i++) mw[i] = 0;
        pend_v = 1'b0;
      end else if (load_en) begin
        for (int i = 0; i < LEN; i++) mw[i] = sx(load_packed[i*WIDTH +: WIDTH]);
        pend_v = 1'b0;
      end else begin
        if (pend_v) begin
          for (int i = 0; i < LEN; i++) mw[i] = lane_next(mw[i], pend_mu, pend_x[i]);
          exp_wv = 1'b1;
          exp_q.push_back(pack_model());
        end
        pend_v = upd_valid;
        pend_mu = sx(mu_err);
        for (int i = 0; i < LEN; i++) pend_x[i] = sx(x_packed[i*WIDTH +: WIDTH]);
      end
      tick();
      n_checks++; if (w_packed !== pack_model()) begin n_fail++; $display("FAIL rand_w c=%0d got=%h exp=%h", c, w_packed, pack_model()); end
      n_checks++; if (w_valid !== exp_wv || busy !== pend_v) begin
        n_fail++; $display("FAIL rand_ctl c=%0d wv=%b busy=%b exp=%b/%b", c, w_valid, busy, exp_wv, pend_v);
      end
      if (w_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_sb c=%0d unexpected w_valid got=%h exp=none", c, w_packed);
        end else begin
          got_exp = exp_q.pop_front();
          if (w_packed !== got_exp) begin n_fail++; $display("FAIL rand_sb c=%0d got=%h exp=%h", c, w_packed, got_exp); end
        end
      end
    end
    clear = 1'b0; load_en = 1'b0; upd_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain got=%0d pending exp=0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    upd_valid = 1'b0; load_en = 1'b0; clear = 1'b0;
    mu_err = '0; x_packed = '0; load_packed = '0;
    pend_v = 1'b0; pend_mu = 0;
    for (int i = 0; i < LEN; i++) begin mw[i] = 0; pend_x[i] = 0; end
    tick();
    tick();
    test_reset();
    test_basic();
    test_saturation();
    test_floor();
    test_back_to_back();
    test_precedence();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
